// File: rtl/cache_wb_if.sv
// Processor and line-wide memory signals of the write-back cache.
// The cache takes the slave view; the processor/memory side takes the master view.
interface cache_wb_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORDS  = 2
);
  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned LINE_W  = DATA_W * WORDS;
  localparam int unsigned MADDR_W = ADDR_W - OFF_W;

  logic [ADDR_W-1:0]  pr_addr;
  logic [DATA_W-1:0]  pr_dout;
  logic [DATA_W-1:0]  pr_din;
  logic               pr_rd;
  logic               pr_wr;
  logic               cvalid;
  logic               flush_req;
  logic               flush_busy;
  logic [MADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_din;
  logic [LINE_W-1:0]  mem_dout;
  logic               mem_rd;
  logic               mem_wr;
  logic               mem_done;

  modport master (
    output pr_addr, pr_dout, pr_rd, pr_wr, flush_req, mem_dout, mem_done,
    input  pr_din, cvalid, flush_busy, mem_addr, mem_din, mem_rd, mem_wr
  );

  modport slave (
    input  pr_addr, pr_dout, pr_rd, pr_wr, flush_req, mem_dout, mem_done,
    output pr_din, cvalid, flush_busy, mem_addr, mem_din, mem_rd, mem_wr
  );
endinterface

// File: rtl/cache_wb_param.sv
// Parametrised direct-mapped write-back, write-allocate cache with a
// whole-cache flush sweep and saturating hit/miss/write-back counters.
module cache_wb_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LINES  = 4,
  parameter int unsigned WORDS  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  cache_wb_if.slave        bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);
  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W  = DATA_W * WORDS;
  localparam int unsigned MADDR_W = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_EVICT, S_FETCH, S_SWEEP, S_SWEEP_WB
  } state_t;

  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

  state_t state_q, state_d;

  line_t            data_q  [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic               mem_rd_q, mem_rd_d;
  logic               mem_wr_q, mem_wr_d;
  logic [MADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_din_q, mem_din_d;
  logic               flush_busy_q;
  logic               after_fill_q;

  logic               init_clr, wr_hit, fill, sweep_clean, miss_inc, wb_inc, hit_inc;
  logic [OFF_W-1:0]   pr_off;
  logic [IDX_W-1:0]   pr_idx;
  logic [TAG_W-1:0]   pr_tag;
  logic [MADDR_W-1:0] pr_line;
  logic               req, hit, cvalid, sweep_last;
  line_t              fill_line;

  // Address decode and hit detection
  assign pr_off     = bus.pr_addr[OFF_W-1:0];
  assign pr_idx     = bus.pr_addr[OFF_W +: IDX_W];
  assign pr_tag     = bus.pr_addr[ADDR_W-1 -: TAG_W];
  assign pr_line    = bus.pr_addr[ADDR_W-1:OFF_W];
  assign req        = bus.pr_rd | bus.pr_wr;
  assign hit        = valid_q[pr_idx] && (tag_q[pr_idx] == pr_tag);
  assign cvalid     = req && hit && (state_q == S_IDLE);
  assign sweep_last = (sweep_idx_q == IDX_W'(LINES - 1));

  // The first IDLE cycle after a fill completes a request already counted as a miss
  assign hit_inc = cvalid && !after_fill_q;

  assign bus.cvalid     = cvalid;
  assign bus.pr_din     = data_q[pr_idx][pr_off];
  assign bus.flush_busy = flush_busy_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;

  always_comb begin
    fill_line = line_t'(bus.mem_dout);
    if (bus.pr_wr) fill_line[pr_off] = bus.pr_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    init_clr    = 1'b0;
    wr_hit      = 1'b0;
    fill        = 1'b0;
    sweep_clean = 1'b0;
    miss_inc    = 1'b0;
    wb_inc      = 1'b0;
    case (state_q)
      S_INIT: begin
        init_clr = 1'b1;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            wr_hit = bus.pr_wr;
          end else begin
            miss_inc = 1'b1;
            if (valid_q[pr_idx] && dirty_q[pr_idx]) begin
              mem_wr_d   = 1'b1;
              mem_addr_d = {tag_q[pr_idx], pr_idx};
              mem_din_d  = data_q[pr_idx];
              state_d    = S_EVICT;
            end else begin
              mem_rd_d   = 1'b1;
              mem_addr_d = pr_line;
              state_d    = S_FETCH;
            end
          end
        end else if (bus.flush_req) begin
          sweep_idx_d = '0;
          state_d     = S_SWEEP;
        end
      end
      S_EVICT: begin
        if (bus.mem_done) begin
          mem_wr_d   = 1'b0;
          mem_rd_d   = 1'b1;
          mem_addr_d = pr_line;
          wb_inc     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.mem_done) begin
          fill     = 1'b1;
          mem_rd_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (valid_q[sweep_idx_q] && dirty_q[sweep_idx_q]) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = {tag_q[sweep_idx_q], sweep_idx_q};
          mem_din_d  = data_q[sweep_idx_q];
          state_d    = S_SWEEP_WB;
        end else begin
          sweep_idx_d = sweep_idx_q + IDX_W'(1);
          if (sweep_last) state_d = S_IDLE;
        end
      end
      S_SWEEP_WB: begin
        if (bus.mem_done) begin
          mem_wr_d    = 1'b0;
          sweep_clean = 1'b1;
          wb_inc      = 1'b1;
          sweep_idx_d = sweep_idx_q + IDX_W'(1);
          state_d     = sweep_last ? S_IDLE : S_SWEEP;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Registered memory strobes and sweep bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      flush_busy_q <= 1'b0;
      sweep_idx_q  <= '0;
      after_fill_q <= 1'b0;
    end else begin
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      flush_busy_q <= (state_d == S_SWEEP) || (state_d == S_SWEEP_WB);
      sweep_idx_q  <= sweep_idx_d;
      after_fill_q <= fill;
    end
  end

  // Line state: valid, dirty and tag
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (init_clr) begin
        valid_q <= '0;
        dirty_q <= '0;
        for (int unsigned i = 0; i < LINES; i++) tag_q[i] <= '0;
      end
      if (wr_hit) dirty_q[pr_idx] <= 1'b1;
      if (fill) begin
        tag_q[pr_idx]   <= pr_tag;
        valid_q[pr_idx] <= 1'b1;
        dirty_q[pr_idx] <= bus.pr_wr;
      end
      if (sweep_clean) dirty_q[sweep_idx_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill)        data_q[pr_idx]         <= fill_line;
    else if (wr_hit) data_q[pr_idx][pr_off] <= bus.pr_dout;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= sat_inc(hit_cnt);
      if (miss_inc) miss_cnt <= sat_inc(miss_cnt);
      if (wb_inc)   wb_cnt   <= sat_inc(wb_cnt);
    end
  end
endmodule

// File: tb/tb_cache_wb_param.sv
// Directed bench for cache_wb_param: table of processor requests on the
// default geometry, plus flush, mid-fetch reset and a wide-geometry sequence.
module tb_cache_wb_param;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] hit1, miss1, wb1;
  logic [15:0] hit2, miss2, wb2;

  cache_wb_if #(.DATA_W(8),  .ADDR_W(6),  .WORDS(2)) b1 ();
  cache_wb_if #(.DATA_W(16), .ADDR_W(10), .WORDS(4)) b2 ();

  cache_wb_param #(.DATA_W(8), .ADDR_W(6), .LINES(4), .WORDS(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave),
    .hit_cnt(hit1), .miss_cnt(miss1), .wb_cnt(wb1)
  );

  cache_wb_param #(.DATA_W(16), .ADDR_W(10), .LINES(8), .WORDS(4), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave),
    .hit_cnt(hit2), .miss_cnt(miss2), .wb_cnt(wb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic        miss;
    logic        wb;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  fetch_addr;
    logic [15:0] mline;
    logic [7:0]  rdata;
    logic [15:0] e_hit;
    logic [15:0] e_miss;
    logic [15:0] e_wb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One processor request on dut1; memory responds one cycle after each strobe check
  task automatic do_req(input vec_t v, input string nm);
    b1.pr_addr = v.addr;
    b1.pr_dout = v.wdata;
    b1.pr_rd   = !v.is_wr;
    b1.pr_wr   = v.is_wr;
    @(negedge clk);
    if (!v.miss) begin
      check({nm, " hit cvalid"}, 64'(b1.cvalid), 64'd1);
      check({nm, " hit no mem"}, 64'({b1.mem_rd, b1.mem_wr}), 64'd0);
      if (!v.is_wr) check({nm, " hit rdata"}, 64'(b1.pr_din), 64'(v.rdata));
    end else begin
      check({nm, " miss cvalid"}, 64'(b1.cvalid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      if (v.wb) begin
        check({nm, " evict wr"},   64'({b1.mem_wr, b1.mem_rd}), 64'b10);
        check({nm, " evict addr"}, 64'(b1.mem_addr), 64'(v.wb_addr));
        check({nm, " evict data"}, 64'(b1.mem_din), 64'(v.wb_data));
        @(posedge clk);
        @(negedge clk);
        check({nm, " evict hold"}, 64'(b1.mem_wr), 64'd1);
        b1.mem_done = 1'b1;
        @(posedge clk);
        #1 b1.mem_done = 1'b0;
        @(negedge clk);
      end
      check({nm, " fetch rd"},   64'({b1.mem_rd, b1.mem_wr}), 64'b10);
      check({nm, " fetch addr"}, 64'(b1.mem_addr), 64'(v.fetch_addr));
      b1.mem_dout = v.mline;
      b1.mem_done = 1'b1;
      @(posedge clk);
      #1 b1.mem_done = 1'b0;
      @(negedge clk);
      check({nm, " fill cvalid"}, 64'(b1.cvalid), 64'd1);
      check({nm, " fill rdata"},  64'(b1.pr_din), 64'(v.rdata));
    end
    @(posedge clk);
    #1;
    b1.pr_rd = 1'b0;
    b1.pr_wr = 1'b0;
    check({nm, " cnt"}, {16'd0, hit1, miss1, wb1}, {16'd0, v.e_hit, v.e_miss, v.e_wb});
  endtask

  // Flush sweep on dut1 with a bounded wait; acknowledges each write-back at once
  task automatic do_flush(input string nm, output int nwr, output int busy, output int nrd,
                          output logic [4:0] a0, output logic [15:0] d0,
                          output logic [4:0] a1, output logic [15:0] d1);
    bit fin = 0;
    nwr = 0; busy = 0; nrd = 0; a0 = '0; d0 = '0; a1 = '0; d1 = '0;
    b1.flush_req = 1'b1;
    @(negedge clk);
    check({nm, " busy at accept"}, 64'(b1.flush_busy), 64'd0);
    @(posedge clk);
    #1 b1.flush_req = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (!b1.flush_busy) begin
        fin = 1;
      end else begin
        busy++;
        if (b1.mem_rd) nrd++;
        if (b1.mem_wr) begin
          if (nwr == 0) begin a0 = b1.mem_addr; d0 = b1.mem_din; end
          else          begin a1 = b1.mem_addr; d1 = b1.mem_din; end
          nwr++;
          b1.mem_done = 1'b1;
        end
        @(posedge clk);
        #1 b1.mem_done = 1'b0;
      end
    end
    check({nm, " sweep ended"}, 64'(fin), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nwr, busy, nrd;
    logic [4:0]  a0, a1;
    logic [15:0] d0, d1;

    //          wr    addr   wdata  miss  wb    wbaddr wbdata    fetch  mline      rdata  hit    miss   wb
    vecs[0] = '{1'b0, 6'h05, 8'h00, 1'b1, 1'b0, 5'h00, 16'h0000, 5'h02, 16'hBEEF, 8'hBE, 16'd0, 16'd1, 16'd0};
    vecs[1] = '{1'b1, 6'h04, 8'h5A, 1'b0, 1'b0, 5'h00, 16'h0000, 5'h00, 16'h0000, 8'h00, 16'd1, 16'd1, 16'd0};
    vecs[2] = '{1'b0, 6'h04, 8'h00, 1'b0, 1'b0, 5'h00, 16'h0000, 5'h00, 16'h0000, 8'h5A, 16'd2, 16'd1, 16'd0};
    vecs[3] = '{1'b0, 6'h24, 8'h00, 1'b1, 1'b1, 5'h02, 16'hBE5A, 5'h12, 16'h1122, 8'h22, 16'd2, 16'd2, 16'd1};
    vecs[4] = '{1'b0, 6'h25, 8'h00, 1'b0, 1'b0, 5'h00, 16'h0000, 5'h00, 16'h0000, 8'h11, 16'd3, 16'd2, 16'd1};
    vecs[5] = '{1'b1, 6'h01, 8'h77, 1'b1, 1'b0, 5'h00, 16'h0000, 5'h00, 16'h3344, 8'h77, 16'd3, 16'd3, 16'd1};
    vecs[6] = '{1'b1, 6'h36, 8'h99, 1'b1, 1'b0, 5'h00, 16'h0000, 5'h1B, 16'h5566, 8'h99, 16'd3, 16'd4, 16'd1};
    vecs[7] = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 5'h00, 16'h0000, 5'h00, 16'h0000, 8'h44, 16'd4, 16'd4, 16'd1};

    reset = 1'b1;
    b1.pr_addr = '0; b1.pr_dout = '0; b1.pr_rd = 1'b0; b1.pr_wr = 1'b0;
    b1.flush_req = 1'b0; b1.mem_dout = '0; b1.mem_done = 1'b0;
    b2.pr_addr = '0; b2.pr_dout = '0; b2.pr_rd = 1'b0; b2.pr_wr = 1'b0;
    b2.flush_req = 1'b0; b2.mem_dout = '0; b2.mem_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst mem_rd",     64'(b1.mem_rd),     64'd0);
    check("rst mem_wr",     64'(b1.mem_wr),     64'd0);
    check("rst mem_addr",   64'(b1.mem_addr),   64'd0);
    check("rst mem_din",    64'(b1.mem_din),    64'd0);
    check("rst flush_busy", 64'(b1.flush_busy), 64'd0);
    check("rst cvalid",     64'(b1.cvalid),     64'd0);
    check("rst counters",   {16'd0, hit1, miss1, wb1}, 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) do_req(vecs[i], $sformatf("v%0d", i));

    // Lines 0 and 3 are dirty here; line 2 is clean, line 1 invalid
    do_flush("flush1", nwr, busy, nrd, a0, d0, a1, d1);
    check("flush1 writes", 64'(nwr),  64'd2);
    check("flush1 addr0",  64'(a0),   64'h00);
    check("flush1 data0",  64'(d0),   64'h7744);
    check("flush1 addr1",  64'(a1),   64'h1B);
    check("flush1 data1",  64'(d1),   64'h5599);
    check("flush1 cycles", 64'(busy), 64'd6);
    check("flush1 no rd",  64'(nrd),  64'd0);
    check("flush1 wb_cnt", 64'(wb1),  64'd3);

    do_req('{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 5'h00, 16'h0, 5'h00, 16'h0, 8'h44, 16'd5, 16'd4, 16'd3}, "post0");
    do_req('{1'b0, 6'h37, 8'h00, 1'b0, 1'b0, 5'h00, 16'h0, 5'h00, 16'h0, 8'h55, 16'd6, 16'd4, 16'd3}, "post3");

    do_flush("flush2", nwr, busy, nrd, a0, d0, a1, d1);
    check("flush2 writes", 64'(nwr),  64'd0);
    check("flush2 cycles", 64'(busy), 64'd4);

    // Reset while a fetch is outstanding, with mem_done arriving on the reset edge
    b1.pr_addr = 6'h0A;
    b1.pr_rd   = 1'b1;
    @(negedge clk);
    check("rstf miss cvalid", 64'(b1.cvalid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstf fetch rd",   64'(b1.mem_rd),   64'd1);
    check("rstf fetch addr", 64'(b1.mem_addr), 64'h05);
    reset       = 1'b1;
    b1.mem_dout = 16'hABCD;
    b1.mem_done = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    b1.mem_done = 1'b0;
    b1.pr_rd    = 1'b0;
    @(negedge clk);
    check("rstf mem_rd",   64'(b1.mem_rd), 64'd0);
    check("rstf counters", {16'd0, hit1, miss1, wb1}, 64'd0);
    @(posedge clk);
    #1;
    do_req('{1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 5'h00, 16'h0, 5'h00, 16'h1234, 8'h34, 16'd0, 16'd1, 16'd0}, "rstf reread");

    // Wide geometry: 16-bit words, 4 words per line, 8 lines
    b2.pr_addr = 10'h107;
    b2.pr_rd   = 1'b1;
    @(negedge clk);
    check("w16 miss cvalid", 64'(b2.cvalid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("w16 fetch rd",   64'(b2.mem_rd),   64'd1);
    check("w16 fetch addr", 64'(b2.mem_addr), 64'h41);
    b2.mem_dout = 64'h4444_3333_2222_1111;
    b2.mem_done = 1'b1;
    @(posedge clk);
    #1 b2.mem_done = 1'b0;
    @(negedge clk);
    check("w16 fill cvalid", 64'(b2.cvalid), 64'd1);
    check("w16 fill rdata",  64'(b2.pr_din), 64'h4444);
    @(posedge clk);
    #1;
    b2.pr_rd   = 1'b0;
    b2.pr_addr = 10'h105;
    b2.pr_dout = 16'hAAAA;
    b2.pr_wr   = 1'b1;
    @(negedge clk);
    check("w16 write hit", 64'(b2.cvalid), 64'd1);
    @(posedge clk);
    #1;
    b2.pr_wr   = 1'b0;
    b2.pr_addr = 10'h124;
    b2.pr_rd   = 1'b1;
    @(negedge clk);
    check("w16 evict cvalid", 64'(b2.cvalid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("w16 evict wr",   64'({b2.mem_wr, b2.mem_rd}), 64'b10);
    check("w16 evict addr", 64'(b2.mem_addr), 64'h41);
    check("w16 evict data", b2.mem_din, 64'h4444_3333_AAAA_1111);
    b2.mem_done = 1'b1;
    @(posedge clk);
    #1 b2.mem_done = 1'b0;
    @(negedge clk);
    check("w16 refetch rd",   64'({b2.mem_rd, b2.mem_wr}), 64'b10);
    check("w16 refetch addr", 64'(b2.mem_addr), 64'h49);
    b2.mem_dout = 64'h0807_0605_0403_0201;
    b2.mem_done = 1'b1;
    @(posedge clk);
    #1 b2.mem_done = 1'b0;
    @(negedge clk);
    check("w16 refill rdata", 64'(b2.pr_din), 64'h0201);
    @(posedge clk);
    #1 b2.pr_rd = 1'b0;
    check("w16 counters", {16'd0, hit2, miss2, wb2}, {16'd0, 16'd1, 16'd2, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/cache_wb_param.md
# cache_wb_param

Parametrised direct-mapped, write-back, write-allocate cache sitting between the processor port and the line-wide memory port. It generalises our fixed 4-line, 2-word, 8-bit cache in word width, line count, words per line and address width. It adds an explicit whole-cache flush (write-back sweep) and saturating hit/miss/write-back statistics counters. A miss evicts a dirty victim with a full-line write, then fetches the requested line with a full-line read.

## Interface
- DATA_W, 8, processor word width in bits
- ADDR_W, 6, processor word-address width
- LINES, 4, number of cache lines (power of 2, ≥2)
- WORDS, 2, words per line (power of 2, ≥2)
- CNT_W, 16, statistics counter width
- Derived: OFF_W=log2(WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W (≥1), LINE_W=DATA_W*WORDS, MADDR_W=ADDR_W-OFF_W

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pr_addr  in  ADDR_W  word address: {tag, index, offset}
- pr_dout  in  DATA_W  processor write data
- pr_din  out  DATA_W  read data for pr_addr: data[index][offset], combinational
- pr_rd, pr_wr  in  1  request strobes; never both high
- cvalid  out  1  request completes this cycle
- flush_req  in  1  request a write-back sweep of all dirty lines
- flush_busy  out  1  sweep in progress
- mem_addr  out  MADDR_W  line address
- mem_din  out  LINE_W  write-back line data
- mem_dout  in  LINE_W  fetched line data
- mem_rd, mem_wr  out  1  memory strobes, never both high
- mem_done  in  1  memory transaction complete, single-cycle pulse
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W  statistics

## Operation
- Word w of a line maps to mem bits [w*DATA_W +: DATA_W]. Line address = {tag, index}.
- hit = valid[index] & tag[index]==pr_tag. cvalid = (pr_rd|pr_wr) & hit & state==IDLE.
- States: INIT, IDLE, EVICT, FETCH, SWEEP, SWEEP_WB.
- INIT: clear all valid and dirty bits and all tags. Go to IDLE after 1 cycle.
- IDLE, request present:
  - Hit: read data appears on pr_din. A write stores pr_dout into data[index][offset] and sets dirty.
  - Miss with victim valid & dirty: go to EVICT. Drive mem_wr=1, mem_addr={victim tag, index}, mem_din=victim line.
  - Miss otherwise: go to FETCH. Drive mem_rd=1, mem_addr=pr_addr[ADDR_W-1:OFF_W].
  - Every miss increments miss_cnt.
- IDLE, no request, flush_req=1: go to SWEEP with the sweep index at 0. Requests take priority over flush_req.
- EVICT: hold all memory outputs. On mem_done: mem_wr=0, mem_rd=1, mem_addr=requested line, wb_cnt++. Go to FETCH.
- FETCH: hold outputs. On mem_done:
  - Load the line from mem_dout, set the tag, valid=1, dirty=0, mem_rd=0.
  - If pr_wr, merge pr_dout into the addressed word and set dirty=1.
  - Return to IDLE. The request then hits and is reported by cvalid there.
- SWEEP: at the current index:
  - Line valid & dirty: drive mem_wr=1, mem_addr={tag,idx}, mem_din=line. Go to SWEEP_WB.
  - Otherwise: idx++ (1 cycle per clean line).
  - After idx LINES-1 is handled: go to IDLE.
- SWEEP_WB: on mem_done: mem_wr=0, clear dirty (line stays valid), wb_cnt++, idx++. Go back to SWEEP, or to IDLE after the last index.
- hit_cnt increments on cvalid, except in the first IDLE cycle after a FETCH completes. That completion is already counted as a miss.
- All counters saturate at 2^CNT_W-1.
- The processor holds pr_addr, pr_rd/pr_wr and pr_dout stable until cvalid. Behaviour is undefined otherwise.

## Timing
- Reset values: mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0, flush_busy=0, all counters 0, state INIT.
- cvalid=0 during INIT, and for one cycle after reset deasserts.
- Reset mid-operation has priority over every state. Strobes drop at the next edge and in-flight mem_done is ignored. INIT then invalidates every line; dirty data is lost.
- Hit latency: 0 cycles. cvalid is high in the same cycle the request is presented in IDLE, and a write commits at that edge.
- Clean miss: mem_rd rises 1 cycle after the request. cvalid comes 1 cycle after the mem_done cycle.
- Dirty miss: mem_wr rises 1 cycle after the request. mem_rd rises in the cycle after the write's mem_done, with no idle cycle between the strobes.
- Strobes stay high until mem_done is sampled high, then drop (or switch) at that edge.
- flush_busy is high from the cycle after acceptance through the last SWEEP/SWEEP_WB cycle. It is 0 again in the first IDLE cycle.
- A sweep with no dirty lines takes exactly LINES cycles.

## Test plan
- Defaults, after reset: read 0x05 misses.
  - Next cycle: mem_rd=1, mem_addr=0x02.
  - Return mem_dout=0xBEEF with mem_done. The next cycle gives cvalid=1, pr_din=0xBE, miss_cnt=1, hit_cnt=0.
- Write 0x5A to 0x04 after that fill: cvalid in the same cycle, no memory activity. A subsequent read of 0x04 returns 0x5A and gives hit_cnt=2.
- Then read 0x24 (dirty victim at index 2):
  - mem_wr=1, mem_addr=0x02, mem_din=0xBE5A.
  - After mem_done: mem_rd=1, mem_addr=0x12 in the next cycle, and wb_cnt=1.
- Lines at indices 0 and 3 dirty, then pulse flush_req:
  - Exactly two mem_wr transactions, index 0 then index 3, with flush_busy high throughout.
  - Afterwards, reads of both lines hit with no memory traffic, and a second flush generates no mem_wr and lasts 4 cycles.
- Assert reset while mem_rd is high in FETCH:
  - mem_rd=0 next cycle and all counters 0.
  - A later read of the previously cached address misses.
- DATA_W=16, ADDR_W=10, LINES=8, WORDS=4:
  - Read word 3 of line 0x41 and return mem_dout=0x4444_3333_2222_1111: pr_din=0x4444.
  - Write word 1 then force eviction: mem_din carries the merged word.
